vram_arbiter: RTL and testbench

//  Owns the single port of the 6912-byte Spectrum screen RAM (bitmap 0x0000-0x17FF, attributes 0x1800-0x1AFF).

---
 rtl/vram_arbiter.sv | 152 +++++++++++++++
 tb/tb_vram_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Screen RAM port owner: snoops Z80 writes into a small FIFO and
// shares the single RAM port with the video fetch path.
module vram_arbiter #(
   parameter int          FIFO_DEPTH  = 4,
   parameter int          MAX_VID_RUN = 8,
   parameter logic [15:0] VRAM_BASE   = 16'h4000,
   parameter logic [15:0] VRAM_LAST   = 16'h5AFF
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [15:0] A,
   input  logic [7:0]  D,
   input  logic        WR,
   input  logic        MRQ,
   input  logic        VID_REQ,
   input  logic [12:0] VID_ADDR,
   output logic        VID_GNT,
   output logic        VID_VALID,
   output logic [7:0]  VID_RDATA,
   output logic [12:0] RAM_ADDR,
   output logic        RAM_WE,
   output logic [7:0]  RAM_WDATA,
   input  logic [7:0]  RAM_RDATA,
   output logic        WR_OVF,
   output logic        LED1
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int RW = $clog2(MAX_VID_RUN + 1);

   logic          rst_q;
   logic          rst_n;
   logic          wr_s1;
   logic          wr_s2;
   logic          mrq_s1;
   logic [15:0]   a_s1;
   logic [7:0]    d_s1;
   logic [20:0]   mem [FIFO_DEPTH];
   logic [20:0]   head;
   logic [PW-1:0] wp;
   logic [PW-1:0] rp;
   logic [CW-1:0] cnt;
   logic [RW-1:0] vid_run;
   logic          rd_p1;
   logic          rd_p2;
   logic          empty;
   logic          full;
   logic          frc;
   logic          gnt;
   logic          pop;
   logic          in_win;
   logic          hit;
   logic          push;
   logic          drop;

   // Assert immediately, release only on a clock edge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rst_q <= 1'b0;
         rst_n <= 1'b0;
      end else begin
         rst_q <= 1'b1;
         rst_n <= rst_q;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         wr_s1  <= 1'b1;
         wr_s2  <= 1'b1;
         mrq_s1 <= 1'b1;
         a_s1   <= '0;
         d_s1   <= '0;
      end else begin
         wr_s1  <= WR;
         wr_s2  <= wr_s1;
         mrq_s1 <= MRQ;
         a_s1   <= A;
         d_s1   <= D;
      end
   end

   assign empty  = (cnt == '0);
   assign full   = (cnt == CW'(FIFO_DEPTH));
   assign frc    = !empty && (vid_run == RW'(MAX_VID_RUN));
   assign gnt    = rst_n && VID_REQ && !frc;
   assign pop    = rst_n && !empty && !gnt;
   assign in_win = (a_s1 >= VRAM_BASE) && (a_s1 <= VRAM_LAST);
   assign hit    = wr_s2 && !wr_s1 && !mrq_s1 && in_win;
   assign push   = hit && (!full || pop);
   assign drop   = hit && full && !pop;
   assign head   = mem[rp];

   assign VID_GNT = gnt;

   always_ff @(posedge CLK) begin
      if (push)
         mem[wp] <= {13'(a_s1 - VRAM_BASE), d_s1};
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         wp        <= '0;
         rp        <= '0;
         cnt       <= '0;
         vid_run   <= '0;
         WR_OVF    <= 1'b0;
         LED1      <= 1'b0;
         RAM_ADDR  <= '0;
         RAM_WE    <= 1'b0;
         RAM_WDATA <= '0;
         rd_p1     <= 1'b0;
         rd_p2     <= 1'b0;
         VID_VALID <= 1'b0;
         VID_RDATA <= '0;
      end else begin
         if (push) begin
            wp   <= wp + 1'b1;
            LED1 <= ~LED1;
         end
         if (pop)
            rp <= rp + 1'b1;
         if (push && !pop)
            cnt <= cnt + 1'b1;
         else if (pop && !push)
            cnt <= cnt - 1'b1;
         if (drop)
            WR_OVF <= 1'b1;
         if (pop || empty)
            vid_run <= '0;
         else if (gnt && (vid_run != RW'(MAX_VID_RUN)))
            vid_run <= vid_run + 1'b1;
         RAM_WE <= pop;
         unique case (1'b1)
            gnt: RAM_ADDR <= VID_ADDR;
            pop: begin
               RAM_ADDR  <= head[20:8];
               RAM_WDATA <= head[7:0];
            end
            default: ;
         endcase
         // Read data appears one cycle after the address; capture it next.
         rd_p1     <= gnt;
         rd_p2     <= rd_p1;
         VID_VALID <= rd_p2;
         if (rd_p2)
            VID_RDATA <= RAM_RDATA;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: snoop window, FIFO drain,
// video read latency, starvation guard, overflow and reset.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] a;
   logic [7:0]  d;
   logic        wr;
   logic        mrq;
   logic        vid_req;
   logic [12:0] vid_addr;
   logic        vid_gnt;
   logic        vid_valid;
   logic [7:0]  vid_rdata;
   logic [12:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata;
   logic        wr_ovf;
   logic        led1;

   logic        b_req;
   logic        b_gnt;
   logic        b_vv;
   logic [7:0]  b_rdata;
   logic [12:0] b_addr;
   logic        b_we;
   logic [7:0]  b_wdata;
   logic        b_ovf;
   logic        b_led;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vram_arbiter u_dut (
      .CLK(clk), .RST(rst), .A(a), .D(d), .WR(wr), .MRQ(mrq),
      .VID_REQ(vid_req), .VID_ADDR(vid_addr),
      .VID_GNT(vid_gnt), .VID_VALID(vid_valid), .VID_RDATA(vid_rdata),
      .RAM_ADDR(ram_addr), .RAM_WE(ram_we), .RAM_WDATA(ram_wdata),
      .RAM_RDATA(ram_rdata), .WR_OVF(wr_ovf), .LED1(led1)
   );

   vram_arbiter #(.MAX_VID_RUN(64)) u_big (
      .CLK(clk), .RST(rst), .A(a), .D(d), .WR(wr), .MRQ(mrq),
      .VID_REQ(b_req), .VID_ADDR(vid_addr),
      .VID_GNT(b_gnt), .VID_VALID(b_vv), .VID_RDATA(b_rdata),
      .RAM_ADDR(b_addr), .RAM_WE(b_we), .RAM_WDATA(b_wdata),
      .RAM_RDATA(8'h00), .WR_OVF(b_ovf), .LED1(b_led)
   );

   // Synchronous read-only RAM: 0x1800 holds 0x38, else low addr byte.
   always @(posedge clk)
      ram_rdata <= (ram_addr == 13'h1800) ? 8'h38 : ram_addr[7:0];

   int          we_cnt = 0;
   int          vv_cnt = 0;
   int          b_we_cnt = 0;
   int          b_vv_cnt = 0;
   int          b_tog = 0;
   logic [12:0] we_addr = '0;
   logic [7:0]  we_data = '0;
   logic        b_led_q = 1'b0;

   always begin
      @(negedge clk);
      #2;
      if (ram_we) begin
         we_cnt++;
         we_addr = ram_addr;
         we_data = ram_wdata;
      end
      if (vid_valid) vv_cnt++;
      if (b_we) b_we_cnt++;
      if (b_vv) b_vv_cnt++;
      if (b_led !== b_led_q) b_tog++;
      b_led_q = b_led;
   end

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic z80_wr(input logic [15:0] addr, input logic [7:0] data);
      @(negedge clk);
      a = addr;
      d = data;
      mrq = 1'b0;
      @(negedge clk);
      wr = 1'b0;
      @(negedge clk);
      wr = 1'b1;
      mrq = 1'b1;
      cyc(4);
   endtask

   int          base;
   int          bw;
   int          bv;
   int          bt;
   logic [15:0] gv;
   logic [15:0] wv;

   initial begin
      rst = 1'b0;
      a = '0;
      d = '0;
      wr = 1'b1;
      mrq = 1'b1;
      vid_req = 1'b1;
      vid_addr = '0;
      b_req = 1'b0;
      cyc(3);
      #1;
      chk("rst_gnt", 32'(vid_gnt), 0);
      chk("rst_we", 32'(ram_we), 0);
      chk("rst_addr", 32'(ram_addr), 0);
      chk("rst_valid", 32'(vid_valid), 0);
      chk("rst_ovf", 32'(wr_ovf), 0);
      chk("rst_led", 32'(led1), 0);
      @(negedge clk);
      vid_req = 1'b0;
      rst = 1'b1;
      cyc(4);

      base = we_cnt;
      z80_wr(16'h4000, 8'hA5);
      chk("w0_we_cnt", 32'(we_cnt - base), 1);
      chk("w0_addr", 32'(we_addr), 0);
      chk("w0_data", 32'(we_data), 32'hA5);
      chk("w0_led", 32'(led1), 1);

      base = we_cnt;
      z80_wr(16'h3FFF, 8'h11);
      z80_wr(16'h5B00, 8'h22);
      chk("win_out_we", 32'(we_cnt - base), 0);
      chk("win_out_led", 32'(led1), 1);
      base = we_cnt;
      z80_wr(16'h5AFF, 8'h5C);
      chk("win_last_we", 32'(we_cnt - base), 1);
      chk("win_last_addr", 32'(we_addr), 32'h1AFF);
      chk("win_last_data", 32'(we_data), 32'h5C);
      chk("win_last_led", 32'(led1), 0);

      @(negedge clk);
      vid_req = 1'b1;
      vid_addr = 13'h1800;
      #3;
      chk("rd_gnt", 32'(vid_gnt), 1);
      @(negedge clk);
      vid_req = 1'b0;
      #3;
      chk("rd_v_k0", 32'(vid_valid), 0);
      @(negedge clk);
      #3;
      chk("rd_v_k1", 32'(vid_valid), 0);
      @(negedge clk);
      #3;
      chk("rd_v_k2", 32'(vid_valid), 1);
      chk("rd_data", 32'(vid_rdata), 32'h38);
      @(negedge clk);
      #3;
      chk("rd_v_k3", 32'(vid_valid), 0);

      gv = '0;
      wv = '0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (i == 0) begin
            vid_req = 1'b1;
            vid_addr = 13'h0010;
            a = 16'h4005;
            d = 8'h77;
            mrq = 1'b0;
         end
         if (i == 1) wr = 1'b0;
         if (i == 3) begin
            wr = 1'b1;
            mrq = 1'b1;
         end
         #3;
         gv[i] = vid_gnt;
         wv[i] = ram_we;
      end
      vid_req = 1'b0;
      chk("starve_gnt", 32'(gv), 32'hF7FF);
      chk("starve_we", 32'(wv), 32'h1000);
      chk("starve_addr", 32'(we_addr), 32'h0005);

      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      cyc(4);

      bt = b_tog;
      bw = b_we_cnt;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (i == 0) begin
            b_req = 1'b1;
            a = 16'h4100;
            d = 8'h00;
            mrq = 1'b0;
         end
         if ((i % 2) == 1 && i <= 9) wr = 1'b0;
         if ((i % 2) == 0 && i >= 2 && i <= 10) begin
            wr = 1'b1;
            a = 16'(16'h4100 + i);
            d = 8'(i);
         end
      end
      mrq = 1'b1;
      #3;
      chk("ovf_set", 32'(b_ovf), 1);
      chk("ovf_led_tog", 32'(b_tog - bt), 4);
      chk("ovf_hold_we", 32'(b_we_cnt - bw), 0);
      chk("ovf_main", 32'(wr_ovf), 0);

      @(negedge clk);
      b_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      b_req = 1'b1;
      #3;
      chk("drain2_we", 32'(b_we_cnt - bw), 2);

      @(negedge clk);
      #4;
      rst = 1'b0;
      #1;
      chk("arst_gnt", 32'(b_gnt), 0);
      chk("arst_valid", 32'(b_vv), 0);
      chk("arst_we", 32'(b_we), 0);
      chk("arst_addr", 32'(b_addr), 0);
      chk("arst_ovf", 32'(b_ovf), 0);
      bw = b_we_cnt;
      bv = b_vv_cnt;
      b_req = 1'b0;
      cyc(3);
      rst = 1'b1;
      cyc(10);
      chk("post_rst_we", 32'(b_we_cnt - bw), 0);
      chk("post_rst_valid", 32'(b_vv_cnt - bv), 0);
      chk("post_rst_ovf", 32'(b_ovf), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
